leg_core: RTL

Parametrised multi-cycle core that executes 4-byte LEG instructions (opcode, arg1, arg2, dest) fetched from an external program memory. Successor to the fixed 8-bit, 6-register core:
- data width and register count are configurable
- owns its program counter and fetch sequencing
- executes conditional jumps and a halt
- uses valid/ready handshakes on the I/O ports, replacing level enables

It sits between the program ROM and the board-level I/O.

---
 rtl/leg_core.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/leg_core.sv
// leg_core: multi-cycle LEG core (FETCH -> DECODE -> EXEC -> WB, terminal HALT).
// Build option: define LEG_CORE_SIGNED_CMP_EN for two's-complement LT/LE/GT/GE when opcode[3]=1.
module leg_core #(
  parameter int DW   = 8,
  parameter int NREG = 6,
  parameter int PW   = 8
) (
  input  logic          clk,
  input  logic          res,
  output logic          pmem_en,
  output logic [PW-1:0] pmem_addr,
  input  logic [31:0]   pmem_rdata,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  output logic          in_ready,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          halted,
  output logic [PW-1:0] dbg_pc,
  output logic [2:0]    dbg_state
);

  // Handshakes: a word moves on a rising edge where valid and ready are both high;
  // the producer keeps data stable while valid is high and not yet accepted.

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WB     = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [7:0] SEL_PC = 8'hFE;
  localparam logic [7:0] SEL_IO = 8'hFF;

  state_t        state_q;
  logic [PW-1:0] pc_q;
  logic [31:0]   instr_q;
  logic [DW-1:0] result_q;
  logic          take_q;
  logic [DW-1:0] regs_q [NREG];
  logic          out_valid_q;
  logic [DW-1:0] out_data_q;
  logic          halted_q;

  logic          op_imm1, op_imm2, op_cond, op_halt;
  logic [2:0]    op_code;
  logic [7:0]    arg1, arg2, dest;
  logic          need_in;
  logic [DW-1:0] opa, opb, shamt, alu_d;
  logic          lt, eq, cond_d;
  logic [PW-1:0] pc_inc;

  function automatic logic [DW-1:0] byte_to_data(input logic [7:0] b);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[i] = b[i];
    return r;
  endfunction

  function automatic logic [DW-1:0] pc_to_data(input logic [PW-1:0] p);
    logic [DW-1:0] r;
    r = '0;
    for (int i = 0; i < PW && i < DW; i++) r[i] = p[i];
    return r;
  endfunction

  function automatic logic [PW-1:0] data_to_pc(input logic [DW-1:0] d);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < PW && i < DW; i++) r[i] = d[i];
    return r;
  endfunction

  function automatic logic [PW-1:0] byte_to_pc(input logic [7:0] b);
    logic [PW-1:0] r;
    r = '0;
    for (int i = 0; i < PW && i < 8; i++) r[i] = b[i];
    return r;
  endfunction

  assign op_imm1 = instr_q[7];
  assign op_imm2 = instr_q[6];
  assign op_cond = instr_q[5];
  assign op_halt = instr_q[4];
  assign op_code = instr_q[2:0];
  assign arg1    = instr_q[15:8];
  assign arg2    = instr_q[23:16];
  assign dest    = instr_q[31:24];
  assign pc_inc  = pc_q + PW'(4);

  // A single in_data sample feeds both operands when both select I/O.
  assign need_in = (!op_imm1 && arg1 == SEL_IO) || (!op_imm2 && arg2 == SEL_IO);

  always_comb begin
    opa = '0;
    opb = '0;
    if (op_imm1)              opa = byte_to_data(arg1);
    else if (arg1 == SEL_PC)  opa = pc_to_data(pc_q);
    else if (arg1 == SEL_IO)  opa = in_data;
    else for (int i = 0; i < NREG; i++) if (arg1 == 8'(i)) opa = regs_q[i];
    if (op_imm2)              opb = byte_to_data(arg2);
    else if (arg2 == SEL_PC)  opb = pc_to_data(pc_q);
    else if (arg2 == SEL_IO)  opb = in_data;
    else for (int i = 0; i < NREG; i++) if (arg2 == 8'(i)) opb = regs_q[i];
  end

  always_comb begin
    shamt = opb % DW'(DW);
    alu_d = '0;
    case (op_code)
      3'd0: alu_d = opa + opb;
      3'd1: alu_d = opa - opb;
      3'd2: alu_d = opa & opb;
      3'd3: alu_d = opa | opb;
      3'd4: alu_d = ~opa;
      3'd5: alu_d = opa ^ opb;
      3'd6: alu_d = opa << shamt;
      3'd7: alu_d = opa >> shamt;
      default: alu_d = '0;
    endcase
  end

`ifdef LEG_CORE_SIGNED_CMP_EN
  always_comb begin
    eq = (opa == opb);
    lt = instr_q[3] ? ($signed(opa) < $signed(opb)) : (opa < opb);
  end
`else
  logic unused_sgn;
  assign unused_sgn = instr_q[3];
  always_comb begin
    eq = (opa == opb);
    lt = (opa < opb);
  end
`endif

  always_comb begin
    cond_d = 1'b0;
    case (op_code)
      3'd0: cond_d = eq;
      3'd1: cond_d = !eq;
      3'd2: cond_d = lt;
      3'd3: cond_d = lt || eq;
      3'd4: cond_d = !(lt || eq);
      3'd5: cond_d = !lt;
      3'd6: cond_d = 1'b1;
      3'd7: cond_d = 1'b0;
      default: cond_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      state_q     <= S_FETCH;
      pc_q        <= '0;
      instr_q     <= '0;
      result_q    <= '0;
      take_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      halted_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH: state_q <= S_DECODE;
        S_DECODE: begin
          instr_q <= pmem_rdata;
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          if (!need_in || in_valid) begin
            result_q <= alu_d;
            take_q   <= cond_d;
            if (!op_cond && op_halt) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_WB;
              if (!op_cond && dest == SEL_IO) begin
                out_valid_q <= 1'b1;
                out_data_q  <= alu_d;
              end
            end
          end
        end
        S_WB: begin
          // Architectural state commits only when WB completes.
          if (!out_valid_q || out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_FETCH;
            if (op_cond) begin
              pc_q <= take_q ? byte_to_pc(dest) : pc_inc;
            end else begin
              for (int i = 0; i < NREG; i++) if (dest == 8'(i)) regs_q[i] <= result_q;
              pc_q <= (dest == SEL_PC) ? data_to_pc(result_q) : pc_inc;
            end
          end
        end
        S_HALT: state_q <= S_HALT;
        default: state_q <= S_FETCH;
      endcase
    end
  end

  // Gated by res so the strobe is low while reset is held and rises as soon as it drops.
  assign pmem_en   = (state_q == S_FETCH) && !res;
  assign pmem_addr = pc_q;
  assign in_ready  = (state_q == S_EXEC) && need_in;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign halted    = halted_q;
  assign dbg_pc    = pc_q;
  assign dbg_state = state_q;

endmodule
